decode_stage: RTL
=================

Name: decode_stage

Overview:
- Second-generation RV32I instruction decoder with valid/ready handshakes on both sides, replacing the state-gated decoder.
- Sits between fetch and execute in the pipelined core and registers all decoded control fields.
- Holds a one-entry skid buffer, so fetch can run at full rate while execute back-pressures.
- Adds full RV32I coverage, an optional M extension, illegal-instruction detection, PC pass-through and flush.

Parameters:
- XLEN, 32, datapath and PC width; only 32 is legal.
- ENABLE_M, 0, when 1 decodes the RV32M opcodes; when 0 they are reported as illegal.
- ALU_CTL_W, 5, width of alu_ctl. Must be at least 5 so that the ZERO code (31) fits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held and incoming instructions
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  decoder can accept an instruction
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  XLEN  PC of the bundle
- imm  out  XLEN  sign-extended immediate
- alu_ctl  out  ALU_CTL_W  ALU operation
- alu_src  out  1  ALU operand B: 1 = imm, 0 = rs2
- alu_a_pc  out  1  ALU operand A: 1 = PC (auipc, jal, jalr link), 0 = rs1
- branch_c, branch_uc, branch_relative  out  1 each  conditional branch / unconditional jump / PC-relative target
- mem_read, mem_write  out  1 each  load / store
- mem_size  out  2  access size: 0 = byte, 1 = half, 2 = word
- mem_unsigned  out  1  zero-extend loaded data (lbu, lhu)
- reg_write  out  1  write rd
- read_reg1, read_reg2, write_reg  out  5 each  rs1, rs2, rd
- illegal  out  1  bundle is an illegal instruction

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, skid empty, in_ready=0 while rst_n is low, illegal=0.
  - All control outputs 0; alu_ctl=ZERO; all address fields and imm 0.
  - A reset mid-operation drops both entries; nothing is emitted afterwards.
- Latency and handshake:
  - A transfer happens when in_valid && in_ready at a clock edge. The bundle appears with out_valid=1 at the next edge.
  - in_ready is a registered signal equal to !skid_valid; it does not depend combinationally on out_ready.
  - Output accepted when out_valid && out_ready. Every output stays stable while out_valid && !out_ready.
  - Decode logic is combinational on in_instr. The decoded bundle is written either into the output register (output empty or draining this cycle) or into the skid (output stalled).
  - When the output drains and the skid is full, the skid moves to the output and the skid empties.
  - Simultaneous accept, drain and skid full cannot occur, because in_ready=0 whenever the skid is full.
- Flush:
  - At the next edge out_valid=0 and the skid is cleared.
  - An instruction transferred in the same cycle as flush is discarded.
  - Flush takes priority over every other event.
- Decode rules:
  - Immediates use RISC-V I/S/B/U/J formats. U-type is imm[31:12] followed by 12 zeros.
  - lui: alu_ctl=CHOOSEB, alu_src=1.
  - auipc: alu_ctl=ADD, alu_a_pc=1, alu_src=1.
  - jal: branch_uc=1, branch_relative=1.
  - jalr: branch_uc=1, branch_relative=0.
  - Branches: branch_c=1, branch_relative=1, alu_src=0, alu_ctl = EQ, NE, LT, GE, LTU or GEU.
  - Loads/stores: alu_ctl=ADD; mem_size and mem_unsigned come from funct3.
  - Shifts with imm take shamt in imm[4:0].
- reg_write is 1 for R, I, U and J types, but forced 0 when rd=x0 and forced 0 for stores and branches.
- illegal=1 for any of:
  - an unknown opcode;
  - an unknown funct3 or funct7 combination;
  - an M-extension opcode when ENABLE_M=0.
  When illegal=1: reg_write, mem_read, mem_write, branch_c and branch_uc are 0, and alu_ctl=ZERO.
- ALU codes:
  - AND=0, OR=1, ADD=2, XOR=3, SLL=4, SRL=5, SUB=6, LT=7, GE=8, SRA=9, CHOOSEB=10.
  - LTU=11, GEU=12, EQ=13, NE=14.
  - MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
  - ZERO=31.

Decomposition:
- Package core_pkg holds:
  - the ALU code localparams;
  - the opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - the mem_size encoding;
  - a packed struct dec_bundle_t holding every output field.
- Sub-module decode_comb: purely combinational, instr -> dec_bundle_t, taking the ENABLE_M parameter.
- decode_stage instantiates decode_comb and contains the output and skid registers plus the handshake logic.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle: out_valid=1, imm=0xFFFFFFFF, alu_ctl=2, alu_src=1, reg_write=1, write_reg=1, read_reg1=2.
- out_ready=0 with three back-to-back in_valid -> first two accepted, in_ready=0 on the third. Releasing out_ready emits them in order, one per cycle, with PCs preserved.
- mul x3,x1,x2 (0x022081B3) -> ENABLE_M=0: illegal=1, reg_write=0, alu_ctl=31. ENABLE_M=1: alu_ctl=16, reg_write=1, write_reg=3.
- Opcode 0x7F, then addi x0,x0,0 (0x00000013) -> first: illegal=1. Second (nop): illegal=0, reg_write=0.
- Output stalled, skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; nothing emitted afterwards.
- rst_n pulsed low mid-stall, asynchronously between edges -> out_valid=0 and alu_ctl=31 immediately, without a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared decode definitions for the RV32I(+M) pipeline: ALU codes, opcodes,
// memory-size encoding and the registered decode bundle.
package core_pkg;

    localparam logic [4:0] ALU_AND     = 5'd0;
    localparam logic [4:0] ALU_OR      = 5'd1;
    localparam logic [4:0] ALU_ADD     = 5'd2;
    localparam logic [4:0] ALU_XOR     = 5'd3;
    localparam logic [4:0] ALU_SLL     = 5'd4;
    localparam logic [4:0] ALU_SRL     = 5'd5;
    localparam logic [4:0] ALU_SUB     = 5'd6;
    localparam logic [4:0] ALU_LT      = 5'd7;
    localparam logic [4:0] ALU_GE      = 5'd8;
    localparam logic [4:0] ALU_SRA     = 5'd9;
    localparam logic [4:0] ALU_CHOOSEB = 5'd10;
    localparam logic [4:0] ALU_LTU     = 5'd11;
    localparam logic [4:0] ALU_GEU     = 5'd12;
    localparam logic [4:0] ALU_EQ      = 5'd13;
    localparam logic [4:0] ALU_NE      = 5'd14;
    localparam logic [4:0] ALU_MUL     = 5'd16;
    localparam logic [4:0] ALU_MULH    = 5'd17;
    localparam logic [4:0] ALU_MULHSU  = 5'd18;
    localparam logic [4:0] ALU_MULHU   = 5'd19;
    localparam logic [4:0] ALU_DIV     = 5'd20;
    localparam logic [4:0] ALU_DIVU    = 5'd21;
    localparam logic [4:0] ALU_REM     = 5'd22;
    localparam logic [4:0] ALU_REMU    = 5'd23;
    localparam logic [4:0] ALU_ZERO    = 5'd31;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  alu_ctl;
        logic        alu_src;
        logic        alu_a_pc;
        logic        branch_c;
        logic        branch_uc;
        logic        branch_relative;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        reg_write;
        logic [4:0]  read_reg1;
        logic [4:0]  read_reg2;
        logic [4:0]  write_reg;
        logic        illegal;
    } dec_bundle_t;

    // Quiescent bundle: everything zero except the ALU parked on ZERO
    function automatic dec_bundle_t idle_bundle();
        dec_bundle_t b;
        b         = '0;
        b.alu_ctl = ALU_ZERO;
        return b;
    endfunction

    // Register-register / register-immediate ALU op selected by funct3 alone
    function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3);
        logic [4:0] a;
        case (f3)
            3'd0:    a = ALU_ADD;
            3'd1:    a = ALU_SLL;
            3'd2:    a = ALU_LT;
            3'd3:    a = ALU_LTU;
            3'd4:    a = ALU_XOR;
            3'd5:    a = ALU_SRL;
            3'd6:    a = ALU_OR;
            3'd7:    a = ALU_AND;
            default: a = ALU_ZERO;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I(+M) decoder: raw instruction to decode bundle.
// The pc field is left zero; the stage fills it in.
module decode_comb
    import core_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] instr,
    output dec_bundle_t dec
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic [31:0] imm_sh_s;
    logic        illegal_s;
    dec_bundle_t dec_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u_s  = {instr[31:12], 12'h000};
    assign imm_j_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh_s = {27'd0, instr[24:20]};

    // Opcode/funct decode with illegal-encoding detection
    always_comb begin
        dec_s           = idle_bundle();
        illegal_s       = 1'b0;
        dec_s.read_reg1 = instr[19:15];
        dec_s.read_reg2 = instr[24:20];
        dec_s.write_reg = instr[11:7];
        case (opcode_s)
            OPC_OP: begin
                dec_s.reg_write = 1'b1;
                case (funct7_s)
                    F7_BASE: dec_s.alu_ctl = alu_from_funct3(funct3_s);
                    F7_ALT: begin
                        if (funct3_s == 3'd0) begin
                            dec_s.alu_ctl = ALU_SUB;
                        end else if (funct3_s == 3'd5) begin
                            dec_s.alu_ctl = ALU_SRA;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    F7_MULDIV: begin
                        if (ENABLE_M) begin
                            dec_s.alu_ctl = ALU_MUL | {2'b00, funct3_s};
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.imm       = imm_i_s;
                case (funct3_s)
                    3'd1: begin
                        dec_s.imm = imm_sh_s;
                        if (funct7_s == F7_BASE) begin
                            dec_s.alu_ctl = ALU_SLL;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    3'd5: begin
                        dec_s.imm = imm_sh_s;
                        if (funct7_s == F7_BASE) begin
                            dec_s.alu_ctl = ALU_SRL;
                        end else if (funct7_s == F7_ALT) begin
                            dec_s.alu_ctl = ALU_SRA;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    default: dec_s.alu_ctl = alu_from_funct3(funct3_s);
                endcase
            end
            OPC_LOAD: begin
                dec_s.reg_write    = 1'b1;
                dec_s.mem_read     = 1'b1;
                dec_s.alu_src      = 1'b1;
                dec_s.alu_ctl      = ALU_ADD;
                dec_s.imm          = imm_i_s;
                dec_s.mem_size     = funct3_s[1:0];
                dec_s.mem_unsigned = funct3_s[2];
                case (funct3_s)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: illegal_s = 1'b0;
                    default:                      illegal_s = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_s.mem_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.alu_ctl   = ALU_ADD;
                dec_s.imm       = imm_s_s;
                dec_s.mem_size  = funct3_s[1:0];
                case (funct3_s)
                    3'd0, 3'd1, 3'd2: illegal_s = 1'b0;
                    default:          illegal_s = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                dec_s.branch_c        = 1'b1;
                dec_s.branch_relative = 1'b1;
                dec_s.imm             = imm_b_s;
                case (funct3_s)
                    3'd0:    dec_s.alu_ctl = ALU_EQ;
                    3'd1:    dec_s.alu_ctl = ALU_NE;
                    3'd4:    dec_s.alu_ctl = ALU_LT;
                    3'd5:    dec_s.alu_ctl = ALU_GE;
                    3'd6:    dec_s.alu_ctl = ALU_LTU;
                    3'd7:    dec_s.alu_ctl = ALU_GEU;
                    default: illegal_s     = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec_s.reg_write       = 1'b1;
                dec_s.branch_uc       = 1'b1;
                dec_s.branch_relative = 1'b1;
                dec_s.alu_a_pc        = 1'b1;
                dec_s.alu_ctl         = ALU_ADD;
                dec_s.imm             = imm_j_s;
            end
            OPC_JALR: begin
                dec_s.reg_write = 1'b1;
                dec_s.branch_uc = 1'b1;
                dec_s.alu_a_pc  = 1'b1;
                dec_s.alu_ctl   = ALU_ADD;
                dec_s.imm       = imm_i_s;
                if (funct3_s != 3'd0) begin
                    illegal_s = 1'b1;
                end else begin
                    illegal_s = 1'b0;
                end
            end
            OPC_LUI: begin
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.alu_ctl   = ALU_CHOOSEB;
                dec_s.imm       = imm_u_s;
            end
            OPC_AUIPC: begin
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.alu_a_pc  = 1'b1;
                dec_s.alu_ctl   = ALU_ADD;
                dec_s.imm       = imm_u_s;
            end
            default: illegal_s = 1'b1;
        endcase

        dec_s.reg_write = dec_s.reg_write & (instr[11:7] != 5'd0);

        // An illegal instruction carries no side effects, only its register fields
        if (illegal_s) begin
            dec_s           = idle_bundle();
            dec_s.read_reg1 = instr[19:15];
            dec_s.read_reg2 = instr[24:20];
            dec_s.write_reg = instr[11:7];
            dec_s.illegal   = 1'b1;
        end else begin
            dec_s.illegal = 1'b0;
        end
    end

    assign dec = dec_s;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: output register plus a
// one-entry skid so fetch is never throttled combinationally by execute.
module decode_stage
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit ENABLE_M  = 1'b0,
    parameter int ALU_CTL_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      imm,
    output logic [ALU_CTL_W-1:0] alu_ctl,
    output logic                 alu_src,
    output logic                 alu_a_pc,
    output logic                 branch_c,
    output logic                 branch_uc,
    output logic                 branch_relative,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [1:0]           mem_size,
    output logic                 mem_unsigned,
    output logic                 reg_write,
    output logic [4:0]           read_reg1,
    output logic [4:0]           read_reg2,
    output logic [4:0]           write_reg,
    output logic                 illegal
);

    dec_bundle_t dec_s;
    dec_bundle_t in_bundle_s;
    dec_bundle_t out_r;
    dec_bundle_t out_n_s;
    dec_bundle_t skid_r;
    dec_bundle_t skid_n_s;
    logic        out_valid_r;
    logic        out_valid_n_s;
    logic        skid_valid_r;
    logic        skid_valid_n_s;
    logic        in_ready_r;
    logic        accept_s;
    logic        drain_s;

    decode_comb #(.ENABLE_M(ENABLE_M)) u_decode_comb (
        .instr (in_instr),
        .dec   (dec_s)
    );

    // Attach the fetch PC to the freshly decoded fields
    always_comb begin
        in_bundle_s    = dec_s;
        in_bundle_s.pc = in_pc;
    end

    assign accept_s = in_valid & in_ready_r;
    assign drain_s  = out_valid_r & out_ready;

    // Output/skid steering; the skid always refills the output before new input
    always_comb begin
        out_n_s        = out_r;
        out_valid_n_s  = out_valid_r;
        skid_n_s       = skid_r;
        skid_valid_n_s = skid_valid_r;
        if (flush) begin
            out_valid_n_s  = 1'b0;
            skid_valid_n_s = 1'b0;
        end else if (!out_valid_r || drain_s) begin
            if (skid_valid_r) begin
                out_n_s        = skid_r;
                out_valid_n_s  = 1'b1;
                skid_valid_n_s = 1'b0;
            end else if (accept_s) begin
                out_n_s       = in_bundle_s;
                out_valid_n_s = 1'b1;
            end else begin
                out_valid_n_s = 1'b0;
            end
        end else if (accept_s) begin
            skid_n_s       = in_bundle_s;
            skid_valid_n_s = 1'b1;
        end else begin
            skid_valid_n_s = skid_valid_r;
        end
    end

    // Pipeline state; in_ready is registered as the complement of next skid occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r        <= idle_bundle();
            skid_r       <= idle_bundle();
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b0;
        end else begin
            out_r        <= out_n_s;
            skid_r       <= skid_n_s;
            out_valid_r  <= out_valid_n_s;
            skid_valid_r <= skid_valid_n_s;
            in_ready_r   <= ~skid_valid_n_s;
        end
    end

    assign in_ready        = in_ready_r;
    assign out_valid       = out_valid_r;
    assign out_pc          = out_r.pc;
    assign imm             = out_r.imm;
    assign alu_ctl         = ALU_CTL_W'(out_r.alu_ctl);
    assign alu_src         = out_r.alu_src;
    assign alu_a_pc        = out_r.alu_a_pc;
    assign branch_c        = out_r.branch_c;
    assign branch_uc       = out_r.branch_uc;
    assign branch_relative = out_r.branch_relative;
    assign mem_read        = out_r.mem_read;
    assign mem_write       = out_r.mem_write;
    assign mem_size        = out_r.mem_size;
    assign mem_unsigned    = out_r.mem_unsigned;
    assign reg_write       = out_r.reg_write;
    assign read_reg1       = out_r.read_reg1;
    assign read_reg2       = out_r.read_reg2;
    assign write_reg       = out_r.write_reg;
    assign illegal         = out_r.illegal;

endmodule
